// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
//
// AXI-style memory slave backed by a DEPTH x 32-bit word array. Independent
// write (AW/W/B) and read (AR/R) state machines each hold one outstanding
// burst. Bursts are FIXED (awburst/arburst == 00) or INCR (any other value);
// INCR wraps the word index modulo DEPTH.
//
// Response codes: addresses outside region addr[29:28] == 2'b11 return DECERR;
// writes with awsize != 3'b010 return SLVERR (DECERR wins). Errored writes
// still consume beats up to wlast but store nothing; errored reads return
// zero data for every beat.
//
// Optional build macro AXI_MEM_RESP_DELAY_EN: each read burst waits RD_DELAY
// cycles with rvalid low before its first beat.
//
// Parameters
//   DEPTH     storage size in 32-bit words (power of two)
//   RD_DELAY  first-beat read delay, used only with AXI_MEM_RESP_DELAY_EN
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   aw* (valid/ready/addr/id/len/size/burst)   write address channel
//   w*  (valid/ready/data/last)     write data channel
//   b*  (valid/ready/id/resp/last)  write response channel
//   ar* (valid/ready/addr/id/len/burst)        read address channel
//   r*  (valid/ready/data/resp/id/last)        read data channel
// -----------------------------------------------------------------------------
module axi_mem_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned RD_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        blast,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic [3:0]  rid,
  output logic        rlast
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned DLY_W = $clog2(RD_DELAY + 1) + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] MEM_REGION  = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // awlen is deliberately ignored (wlast alone ends a write burst), and only
  // the index and region fields of the addresses are decoded.
  logic unused_ok;
  assign unused_ok = ^{awlen, awaddr, araddr};

  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------- write FSM
  w_state_e      w_state, w_next;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_id;
  logic          w_fixed;
  logic [1:0]    w_resp;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_idx   <= '0;
      w_id    <= '0;
      w_fixed <= 1'b0;
      w_resp  <= RESP_OKAY;
    end else if (awready && awvalid) begin
      w_idx   <= awaddr[AW+1:2];
      w_id    <= awid;
      w_fixed <= (awburst == BURST_FIXED);
      if (awaddr[29:28] != MEM_REGION) w_resp <= RESP_DECERR;
      else if (awsize != 3'b010)       w_resp <= RESP_SLVERR;
      else                             w_resp <= RESP_OKAY;
    end else if (wready && wvalid && !w_fixed) begin
      w_idx <= w_idx + 1'b1;
    end
  end

  // NOTE: the storage array has no reset: contents survive rst_n and the
  // array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wready && wvalid && (w_resp == RESP_OKAY)) mem[w_idx] <= wdata;
  end

  assign bid   = w_id;
  assign bresp = w_resp;
  assign blast = bvalid;

  // ----------------------------------------------------------------- read FSM
  r_state_e         r_state, r_next;
  logic [AW-1:0]    r_idx;
  logic [3:0]       r_id;
  logic [7:0]       r_len;
  logic [7:0]       r_cnt;
  logic             r_fixed;
  logic [1:0]       r_resp;
  logic [DLY_W-1:0] r_dly;   // first-beat countdown; stays zero without the macro

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = (r_dly == '0);
        rlast  = rvalid && (r_cnt == r_len);
        if (rvalid && rready && rlast) r_next = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      r_resp  <= RESP_OKAY;
      r_dly   <= '0;
    end else if (arready && arvalid) begin
      r_idx   <= araddr[AW+1:2];
      r_id    <= arid;
      r_len   <= arlen;
      r_cnt   <= '0;
      r_fixed <= (arburst == BURST_FIXED);
      r_resp  <= (araddr[29:28] == MEM_REGION) ? RESP_OKAY : RESP_DECERR;
`ifdef AXI_MEM_RESP_DELAY_EN
      r_dly   <= DLY_W'(RD_DELAY);
`else
      r_dly   <= '0;
`endif
    end else if (r_dly != '0) begin
      r_dly <= r_dly - 1'b1;
    end else if (rvalid && rready) begin
      r_cnt <= r_cnt + 1'b1;
      if (!r_fixed) r_idx <= r_idx + 1'b1;
    end
  end

  // Combinational array read: a write landing on this word shows up the
  // cycle after it commits.
  assign rdata = (rvalid && (r_resp == RESP_OKAY)) ? mem[r_idx] : '0;
  assign rresp = r_resp;
  assign rid   = r_id;

endmodule

// File: tb/tb_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_responder
//
// Self-checking bench for axi_mem_responder. A behavioural model (word array,
// known-word flags, response rule, index arithmetic) predicts every response;
// scenario tasks drive bus transactions and compare the observations inline.
// -----------------------------------------------------------------------------
module tb_axi_mem_responder;

  localparam int DEPTH    = 1024;
  localparam int RD_DELAY = 4;
  localparam int MAX_WAIT = 200;
`ifdef AXI_MEM_RESP_DELAY_EN
  localparam int FIRST_LAT = RD_DELAY + 1;
`else
  localparam int FIRST_LAT = 1;
`endif
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [1:0]  FIXED = 2'b00;
  localparam logic [1:0]  INCR  = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'b010;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic        wlast = 1'b0;
  logic        bvalid, bready = 1'b0;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        blast;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  axi_mem_responder #(.DEPTH(DEPTH), .RD_DELAY(RD_DELAY)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .blast(blast),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rid(rid), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ------------------------------------------------------------ reference model
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];

  function automatic logic [1:0] ref_resp(input logic [31:0] addr, input logic [2:0] size);
    if (addr[29:28] != 2'b11) return 2'b11;
    if (size != 3'b010)       return 2'b10;
    return 2'b00;
  endfunction

  function automatic int ref_idx(input logic [31:0] addr, input logic [1:0] burst, input int beat);
    int base;
    base = int'(addr >> 2) % DEPTH;
    return (burst == FIXED) ? base : (base + beat) % DEPTH;
  endfunction

  logic [31:0] wq [$];   // data beats for the next write burst

  function automatic void ref_write(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] burst);
    if (ref_resp(addr, size) != 2'b00) return;
    foreach (wq[i]) begin
      ref_mem[ref_idx(addr, burst, i)]   = wq[i];
      ref_known[ref_idx(addr, burst, i)] = 1'b1;
    end
  endfunction

  // ----------------------------------------------------------- bus observations
  logic [1:0]  obs_bresp;
  logic [3:0]  obs_bid;
  logic        obs_blast;
  int          w_unstable;
  logic [31:0] obs_rdata [$];
  logic [1:0]  obs_rresp [$];
  logic [3:0]  obs_rid   [$];
  logic        obs_rlast [$];
  int          obs_lat;
  int          r_unstable;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int b_stall, input bit gaps);
    int waited;
    bit timed_out;
    timed_out  = 1'b0;
    w_unstable = 0;
    awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    waited = 0;
    while (awready !== 1'b1 && waited < MAX_WAIT) begin step(); waited++; end
    if (waited >= MAX_WAIT) timed_out = 1'b1;
    step();
    awvalid = 1'b0;
    for (int i = 0; i < wq.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      wvalid = 1'b1; wdata = wq[i]; wlast = (i == wq.size() - 1);
      waited = 0;
      while (wready !== 1'b1 && waited < MAX_WAIT) begin step(); waited++; end
      if (waited >= MAX_WAIT) timed_out = 1'b1;
      step();
      wvalid = 1'b0; wlast = 1'b0;
    end
    waited = 0;
    while (bvalid !== 1'b1 && waited < MAX_WAIT) begin step(); waited++; end
    if (waited >= MAX_WAIT) timed_out = 1'b1;
    obs_bresp = bresp; obs_bid = bid; obs_blast = blast;
    repeat (b_stall) begin
      step();
      if ({bvalid, bid, bresp, blast} !== {1'b1, obs_bid, obs_bresp, obs_blast}) w_unstable++;
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    if (timed_out) begin
      n_checks++;
      $display("FAIL write_timeout addr=%h: handshake not seen within %0d cycles", addr, MAX_WAIT);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_beat, input int stall_len, input bit rand_stall);
    int waited;
    int stall;
    bit timed_out;
    logic [39:0] snap;
    timed_out  = 1'b0;
    r_unstable = 0;
    obs_rdata.delete(); obs_rresp.delete(); obs_rid.delete(); obs_rlast.delete();
    araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
    waited = 0;
    while (arready !== 1'b1 && waited < MAX_WAIT) begin step(); waited++; end
    if (waited >= MAX_WAIT) timed_out = 1'b1;
    step();
    arvalid = 1'b0;
    obs_lat = 1;
    while (rvalid !== 1'b1 && obs_lat < MAX_WAIT) begin step(); obs_lat++; end
    for (int i = 0; i <= int'(len); i++) begin
      waited = 0;
      while (rvalid !== 1'b1 && waited < MAX_WAIT) begin step(); waited++; end
      if (waited >= MAX_WAIT) timed_out = 1'b1;
      stall = (i == stall_beat) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      snap = {rvalid, rdata, rresp, rid, rlast};
      repeat (stall) begin
        step();
        if ({rvalid, rdata, rresp, rid, rlast} !== snap) r_unstable++;
      end
      obs_rdata.push_back(rdata); obs_rresp.push_back(rresp);
      obs_rid.push_back(rid);     obs_rlast.push_back(rlast);
      rready = 1'b1;
      step();
      rready = 1'b0;
    end
    if (timed_out) begin
      n_checks++;
      $display("FAIL read_timeout addr=%h: handshake not seen within %0d cycles", addr, MAX_WAIT);
    end
  endtask

  // --------------------------------------------------------------- scenarios
  task automatic test_reset();
    n_checks++;
    if ({awready, arready, wready} !== 3'b110)
      $display("FAIL reset_ready: got aw/ar/w=%b want 110", {awready, arready, wready});
    else n_pass++;
    n_checks++;
    if ({bvalid, blast, rvalid, rlast} !== 4'b0000)
      $display("FAIL reset_valid: got bvalid/blast/rvalid/rlast=%b want 0000", {bvalid, blast, rvalid, rlast});
    else n_pass++;
    n_checks++;
    if ({bresp, rresp, bid, rid, rdata} !== 44'h0)
      $display("FAIL reset_sideband: got bresp=%b rresp=%b bid=%h rid=%h rdata=%h want all zero", bresp, rresp, bid, rid, rdata);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] exp_d [2];
    exp_d[0] = 32'hAAAA_0001;
    exp_d[1] = 32'hBBBB_0002;
    wq = '{32'hAAAA_0001, 32'hBBBB_0002};
    axi_write(32'h3000_0010, 4'h5, 8'd1, INCR, 3'b010, 0, 1'b0);
    ref_write(32'h3000_0010, 3'b010, INCR);
    n_checks++;
    if ({obs_bresp, obs_bid, obs_blast} !== {2'b00, 4'h5, 1'b1})
      $display("FAIL basic_bresp: got bresp=%b bid=%h blast=%b want 00/5/1", obs_bresp, obs_bid, obs_blast);
    else n_pass++;
    axi_read(32'h3000_0010, 4'h9, 8'd1, INCR, -1, 0, 1'b0);
    n_checks++;
    if (obs_lat !== FIRST_LAT) $display("FAIL first_beat_latency: got %0d want %0d", obs_lat, FIRST_LAT);
    else n_pass++;
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({obs_rdata[j], obs_rresp[j], obs_rid[j], obs_rlast[j]} !== {exp_d[j], 2'b00, 4'h9, j == 1})
        $display("FAIL basic_rbeat%0d: got data=%h resp=%b id=%h last=%b want %h/00/9/%0d",
                 j, obs_rdata[j], obs_rresp[j], obs_rid[j], obs_rlast[j], exp_d[j], j == 1);
      else n_pass++;
    end
  endtask

  task automatic test_errors();
    // Known word at index 0, which is what the unmapped address would alias to.
    wq = '{32'h1234_5678};
    axi_write(BASE, 4'h1, 8'd0, INCR, 3'b010, 0, 1'b0);
    ref_write(BASE, 3'b010, INCR);
    wq = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002};
    axi_write(32'h1000_0000, 4'h2, 8'd2, INCR, 3'b010, 0, 1'b1);
    n_checks++;
    if ({obs_bresp, obs_bid} !== {2'b11, 4'h2}) $display("FAIL decerr_bresp: got %b/%h want 11/2", obs_bresp, obs_bid);
    else n_pass++;
    wq = '{32'hBAD0_0001};
    axi_write(BASE, 4'h3, 8'd0, INCR, 3'b000, 0, 1'b0);
    n_checks++;
    if (obs_bresp !== 2'b10) $display("FAIL slverr_bresp: got %b want 10", obs_bresp);
    else n_pass++;
    axi_write(32'h2000_0000, 4'h4, 8'd0, INCR, 3'b001, 0, 1'b0);
    n_checks++;
    if (obs_bresp !== 2'b11) $display("FAIL decerr_priority: got %b want 11", obs_bresp);
    else n_pass++;
    axi_read(BASE, 4'h6, 8'd0, INCR, -1, 0, 1'b0);
    n_checks++;
    if (obs_rdata[0] !== ref_mem[0]) $display("FAIL err_write_no_store: got %h want %h", obs_rdata[0], ref_mem[0]);
    else n_pass++;
    axi_read(32'h1000_0000, 4'h7, 8'd2, INCR, -1, 0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if ({obs_rdata[j], obs_rresp[j], obs_rlast[j]} !== {32'h0, 2'b11, j == 2})
        $display("FAIL decerr_rbeat%0d: got data=%h resp=%b last=%b want 0/11/%0d", j, obs_rdata[j], obs_rresp[j], obs_rlast[j], j == 2);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_and_fixed();
    logic [31:0] top_addr;
    int idx;
    top_addr = BASE + 32'((DEPTH - 1) * 4);
    wq = '{32'h0000_0A00, 32'h0000_0A01, 32'h0000_0A02, 32'h0000_0A03};
    axi_write(top_addr, 4'hA, 8'd3, INCR, 3'b010, 1, 1'b1);
    ref_write(top_addr, 3'b010, INCR);
    axi_read(top_addr, 4'hB, 8'd3, INCR, -1, 0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      idx = (DEPTH - 1 + j) % DEPTH;
      n_checks++;
      if ({obs_rdata[j], obs_rlast[j]} !== {ref_mem[idx], j == 3})
        $display("FAIL wrap_beat%0d idx%0d: got %h last=%b want %h", j, idx, obs_rdata[j], obs_rlast[j], ref_mem[idx]);
      else n_pass++;
    end
    // FIXED write: three beats against awlen=0; only the last lands, neighbour untouched.
    wq = '{32'h5555_0033};
    axi_write(BASE + 32'h84, 4'h1, 8'd0, INCR, 3'b010, 0, 1'b0);
    ref_write(BASE + 32'h84, 3'b010, INCR);
    wq = '{32'hF000_0000, 32'hF000_0001, 32'hF000_0002};
    axi_write(BASE + 32'h80, 4'hC, 8'd0, FIXED, 3'b010, 0, 1'b1);
    ref_write(BASE + 32'h80, 3'b010, FIXED);
    axi_read(BASE + 32'h80, 4'hD, 8'd3, INCR, -1, 0, 1'b0);
    n_checks++;
    if ({obs_rdata[0], obs_rdata[1]} !== {ref_mem[32], ref_mem[33]})
      $display("FAIL fixed_write: got %h %h want %h %h", obs_rdata[0], obs_rdata[1], ref_mem[32], ref_mem[33]);
    else n_pass++;
    axi_read(BASE + 32'h80, 4'hE, 8'd2, FIXED, -1, 0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (obs_rdata[j] !== ref_mem[32]) $display("FAIL fixed_read_beat%0d: got %h want %h", j, obs_rdata[j], ref_mem[32]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    wq = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
    axi_write(BASE + 32'h200, 4'h8, 8'd3, INCR, 3'b010, 3, 1'b0);
    ref_write(BASE + 32'h200, 3'b010, INCR);
    n_checks++;
    if ({w_unstable, obs_bresp, obs_bid} !== {32'd0, 2'b00, 4'h8})
      $display("FAIL b_stall: got unstable=%0d bresp=%b bid=%h want 0/00/8", w_unstable, obs_bresp, obs_bid);
    else n_pass++;
    axi_read(BASE + 32'h200, 4'h3, 8'd3, INCR, 1, 5, 1'b0);
    n_checks++;
    if (r_unstable !== 0) $display("FAIL r_stall_stable: got %0d changes want 0", r_unstable);
    else n_pass++;
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if ({obs_rdata[j], obs_rid[j], obs_rlast[j]} !== {ref_mem[128 + j], 4'h3, j == 3})
        $display("FAIL r_stall_beat%0d: got %h id=%h last=%b want %h", j, obs_rdata[j], obs_rid[j], obs_rlast[j], ref_mem[128 + j]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, exp_d;
    logic [3:0]  id;
    logic [2:0]  size;
    logic [1:0]  burst, exp_r, exp_b;
    int nbeats, idx;
    for (int t = 0; t < 15; t++) begin
      addr = $urandom;
      if ($urandom_range(0, 9) < 7) addr[29:28] = 2'b11;
      size   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      burst  = 2'($urandom_range(0, 2));
      id     = 4'($urandom);
      nbeats = $urandom_range(1, 8);
      wq.delete();
      for (int k = 0; k < nbeats; k++) wq.push_back($urandom);
      exp_b = ref_resp(addr, size);
      axi_write(addr, id, 8'($urandom), burst, size, $urandom_range(0, 2), 1'b1);
      ref_write(addr, size, burst);
      n_checks++;
      if ({obs_bresp, obs_bid, obs_blast} !== {exp_b, id, 1'b1})
        $display("FAIL rand%0d_bresp: got %b/%h/%b want %b/%h/1", t, obs_bresp, obs_bid, obs_blast, exp_b, id);
      else n_pass++;
      axi_read(addr, ~id, 8'(nbeats - 1), burst, -1, 0, 1'b1);
      n_checks++;
      if (obs_lat !== FIRST_LAT) $display("FAIL rand%0d_latency: got %0d want %0d", t, obs_lat, FIRST_LAT);
      else n_pass++;
      exp_r = (addr[29:28] == 2'b11) ? 2'b00 : 2'b11;
      for (int j = 0; j < nbeats; j++) begin
        idx = ref_idx(addr, burst, j);
        if (exp_r == 2'b00 && !ref_known[idx]) continue;
        exp_d = (exp_r == 2'b00) ? ref_mem[idx] : 32'h0;
        n_checks++;
        if ({obs_rdata[j], obs_rresp[j], obs_rid[j], obs_rlast[j]} !== {exp_d, exp_r, ~id, j == nbeats - 1})
          $display("FAIL rand%0d_beat%0d: got %h/%b/%h/%b want %h/%b/%h/%0d", t, j,
                   obs_rdata[j], obs_rresp[j], obs_rid[j], obs_rlast[j], exp_d, exp_r, ~id, j == nbeats - 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    // Preload the read target, then run a write and a read to disjoint words at once.
    wq = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002};
    axi_write(BASE + 32'h300, 4'h2, 8'd2, INCR, 3'b010, 0, 1'b0);
    ref_write(BASE + 32'h300, 3'b010, INCR);
    wq = '{32'h7777_0000, 32'h7777_0001, 32'h7777_0002};
    fork
      axi_write(BASE + 32'h400, 4'h4, 8'd2, INCR, 3'b010, 1, 1'b1);
      axi_read(BASE + 32'h300, 4'h5, 8'd2, INCR, -1, 0, 1'b1);
    join
    ref_write(BASE + 32'h400, 3'b010, INCR);
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (obs_rdata[j] !== ref_mem[192 + j]) $display("FAIL concurrent_rbeat%0d: got %h want %h", j, obs_rdata[j], ref_mem[192 + j]);
      else n_pass++;
    end
    axi_read(BASE + 32'h400, 4'h6, 8'd2, INCR, -1, 0, 1'b0);
    axi_read(BASE + 32'h408, 4'h7, 8'd0, INCR, -1, 0, 1'b0);
    n_checks++;
    if ({obs_rdata[0], obs_rid[0]} !== {ref_mem[258], 4'h7})
      $display("FAIL back_to_back_read: got %h/%h want %h/7", obs_rdata[0], obs_rid[0], ref_mem[258]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int waited;
    wq.delete();
    for (int k = 0; k < 8; k++) wq.push_back($urandom);
    axi_write(BASE + 32'h190, 4'h3, 8'd7, INCR, 3'b010, 0, 1'b0);
    ref_write(BASE + 32'h190, 3'b010, INCR);
    araddr = BASE + 32'h190; arid = 4'h6; arlen = 8'd7; arburst = INCR; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    waited = 0;
    while (rvalid !== 1'b1 && waited < MAX_WAIT) begin step(); waited++; end
    rready = 1'b1;
    step();
    step();
    rready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rvalid, rlast, rdata} !== 34'h0)
      $display("FAIL reset_mid_burst: got rvalid=%b rlast=%b rdata=%h want 0/0/0", rvalid, rlast, rdata);
    else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({arready, awready, rvalid} !== 3'b110)
      $display("FAIL after_reset_ready: got ar/aw/rvalid=%b want 110", {arready, awready, rvalid});
    else n_pass++;
    axi_read(BASE + 32'h190, 4'h2, 8'd7, INCR, -1, 0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if (obs_rdata[j] !== ref_mem[100 + j]) $display("FAIL retained_beat%0d: got %h want %h", j, obs_rdata[j], ref_mem[100 + j]);
      else n_pass++;
    end
  endtask

  initial begin
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic();
    test_errors();
    test_wrap_and_fixed();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid_burst();
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
